// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and output saturation for the 3x3 convolution MAC.
package conv_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned WW    = 8;
    localparam int unsigned ACC_W = 21;
    localparam int unsigned NTAPS = 9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StDone = 2'd2
    } state_e;

    // ReLU followed by clamp to the unsigned 8-bit output range.
    function automatic logic [7:0] relu_sat(input logic signed [31:0] acc);
        if (acc < 0) begin
            return 8'd0;
        end else if (acc > 32'sd255) begin
            return 8'hff;
        end else begin
            return acc[7:0];
        end
    endfunction

endpackage

// File: rtl/conv3x3_mac_seq.sv
// Sequential 3x3 dot product: latches a window and kernel, accumulates one tap per cycle,
// then emits a ReLU-saturated 8-bit result with a one-cycle valid pulse.
module conv3x3_mac_seq #(
    parameter int unsigned DW    = conv_pkg::DW,
    parameter int unsigned WW    = conv_pkg::WW,
    parameter int unsigned ACC_W = conv_pkg::ACC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [DW-1:0] data3,
    input  logic [DW-1:0] data4,
    input  logic [DW-1:0] data5,
    input  logic [DW-1:0] data6,
    input  logic [DW-1:0] data7,
    input  logic [DW-1:0] data8,
    input  logic [WW-1:0] weight0,
    input  logic [WW-1:0] weight1,
    input  logic [WW-1:0] weight2,
    input  logic [WW-1:0] weight3,
    input  logic [WW-1:0] weight4,
    input  logic [WW-1:0] weight5,
    input  logic [WW-1:0] weight6,
    input  logic [WW-1:0] weight7,
    input  logic [WW-1:0] weight8,
    output logic [7:0]    ans,
    output logic          out_valid,
    output logic          busy
);
    import conv_pkg::*;

    localparam int unsigned PW       = DW + WW + 1;
    localparam logic [3:0]  LAST_TAP = 4'(NTAPS - 1);

    state_e state_q, state_d;

    logic [DW-1:0]           data_in  [NTAPS];
    logic [WW-1:0]           weight_in[NTAPS];
    logic [DW-1:0]           data_q   [NTAPS];
    logic [WW-1:0]           weight_q [NTAPS];
    logic [3:0]              tap_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic [7:0]              ans_q;
    logic [DW-1:0]           data_sel;
    logic [WW-1:0]           weight_sel;
    logic signed [PW-1:0]    data_ext;
    logic signed [PW-1:0]    weight_ext;
    logic signed [PW-1:0]    prod;

    assign data_in[0] = data0;
    assign data_in[1] = data1;
    assign data_in[2] = data2;
    assign data_in[3] = data3;
    assign data_in[4] = data4;
    assign data_in[5] = data5;
    assign data_in[6] = data6;
    assign data_in[7] = data7;
    assign data_in[8] = data8;

    assign weight_in[0] = weight0;
    assign weight_in[1] = weight1;
    assign weight_in[2] = weight2;
    assign weight_in[3] = weight3;
    assign weight_in[4] = weight4;
    assign weight_in[5] = weight5;
    assign weight_in[6] = weight6;
    assign weight_in[7] = weight7;
    assign weight_in[8] = weight8;

    // Data is unsigned, so it gets a zero sign bit before the signed multiply.
    always_comb begin
        data_sel   = data_q[tap_q];
        weight_sel = weight_q[tap_q];
        data_ext   = PW'($signed({1'b0, data_sel}));
        weight_ext = PW'($signed(weight_sel));
        prod       = data_ext * weight_ext;
        acc_sum    = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (tap_q == LAST_TAP) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
        ans       = ans_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            tap_q <= '0;
            ans_q <= '0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                data_q[i]   <= '0;
                weight_q[i] <= '0;
            end
        end else if (state_q == StIdle && in_valid) begin
            acc_q <= '0;
            tap_q <= '0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                data_q[i]   <= data_in[i];
                weight_q[i] <= weight_in[i];
            end
        end else if (state_q == StMac) begin
            acc_q <= acc_sum;
            tap_q <= tap_q + 4'd1;
            if (tap_q == LAST_TAP) begin
                ans_q <= relu_sat(32'(acc_sum));
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_seq.sv
// Directed self-checking bench for conv3x3_mac_seq: latency, ReLU/saturation,
// back-to-back throughput, operand isolation and mid-operation reset.
module tb_conv3x3_mac_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] d[9];
    logic [7:0] w[9];
    logic [7:0] ans;
    logic       out_valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv3x3_mac_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .data0    (d[0]),
        .data1    (d[1]),
        .data2    (d[2]),
        .data3    (d[3]),
        .data4    (d[4]),
        .data5    (d[5]),
        .data6    (d[6]),
        .data7    (d[7]),
        .data8    (d[8]),
        .weight0  (w[0]),
        .weight1  (w[1]),
        .weight2  (w[2]),
        .weight3  (w[3]),
        .weight4  (w[4]),
        .weight5  (w[5]),
        .weight6  (w[6]),
        .weight7  (w[7]),
        .weight8  (w[8]),
        .ans      (ans),
        .out_valid(out_valid),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [7:0] dv, input logic [7:0] wv);
        for (int j = 0; j < 9; j++) begin
            d[j] = dv;
            w[j] = wv;
        end
    endtask

    // Reference: plain integer dot product followed by ReLU and clamp.
    function automatic int expect_ans();
        int acc;
        acc = 0;
        for (int j = 0; j < 9; j++) begin
            acc += int'(d[j]) * int'($signed(w[j]));
        end
        if (acc < 0) return 0;
        if (acc > 255) return 255;
        return acc;
    endfunction

    // Caller sits just after a rising edge with the DUT idle.
    task automatic run_one(input string tag, input int exp_ans, input int exp_acc);
        int early;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "/busy_k"}, int'(busy), 1);
        check_eq({tag, "/ov_k"}, int'(out_valid), 0);
        early = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) early++;
        end
        check_eq({tag, "/early_pulse"}, early, 0);
        @(posedge clk); #1;
        check_eq({tag, "/ov"}, int'(out_valid), 1);
        check_eq({tag, "/ans"}, int'(ans), exp_ans);
        check_eq({tag, "/acc"}, int'(dut.acc_q), exp_acc);
        check_eq({tag, "/busy_done"}, int'(busy), 1);
        @(posedge clk); #1;
        check_eq({tag, "/ov_clear"}, int'(out_valid), 0);
        check_eq({tag, "/busy_clear"}, int'(busy), 0);
        check_eq({tag, "/ans_hold"}, int'(ans), exp_ans);
    endtask

    initial begin
        int exp;
        int last;
        int pulses;
        int cnt;
        set_all(8'd0, 8'd0);

        // Reset state
        @(posedge clk); #1;
        check_eq("rst/ans", int'(ans), 0);
        check_eq("rst/ov", int'(out_valid), 0);
        check_eq("rst/busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle/busy", int'(busy), 0);

        // All ones
        set_all(8'd1, 8'd1);
        run_one("ones", 9, 9);

        // Ramp data, unit then negative weights
        for (int j = 0; j < 9; j++) d[j] = 8'(j);
        set_all_w(8'd1);
        run_one("ramp_pos", 36, 36);
        set_all_w(8'hff);
        run_one("ramp_neg", 0, -36);

        // Saturation extremes
        set_all(8'd255, 8'd127);
        run_one("sat_hi", 255, 291465);
        set_all(8'd255, 8'h80);
        run_one("sat_lo", 0, -293760);

        // Back-to-back with in_valid held high, new operands on each pulse
        for (int j = 0; j < 9; j++) begin
            d[j] = 8'(j * 5);
            w[j] = 8'(j - 3);
        end
        exp = expect_ans();
        pulses = 0;
        last = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                check_eq("b2b/ans", int'(ans), exp);
                if (pulses > 0) check_eq("b2b/gap", i - last, 11);
                last = i;
                pulses++;
                for (int j = 0; j < 9; j++) begin
                    d[j] = 8'(pulses * 23 + j * 5);
                    w[j] = 8'(pulses * 7 - j * 3);
                end
                exp = expect_ans();
            end
        end
        in_valid = 1'b0;
        check_eq("b2b/pulses", pulses, 3);
        cnt = 0;
        while (busy && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_eq("b2b/drain", int'(busy), 0);

        // Operands and in_valid disturbed mid-computation
        for (int j = 0; j < 9; j++) begin
            d[j] = 8'(j + 1);
            w[j] = 8'd2;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 9; j++) begin
            d[j] = 8'($urandom_range(0, 255));
            w[j] = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("iso/ov", int'(out_valid), 1);
        check_eq("iso/ans", int'(ans), 90);
        check_eq("iso/acc", int'(dut.acc_q), 90);
        @(posedge clk); #1;
        check_eq("iso/ov_clear", int'(out_valid), 0);
        @(posedge clk); #1;
        check_eq("iso/no_restart", int'(busy), 0);

        // Reset during MAC
        set_all(8'd1, 8'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mrst/ans", int'(ans), 0);
        check_eq("mrst/ov", int'(out_valid), 0);
        check_eq("mrst/busy", int'(busy), 0);
        check_eq("mrst/acc", int'(dut.acc_q), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) cnt++;
        end
        check_eq("mrst/quiet", cnt, 0);
        set_all(8'd2, 8'd3);
        run_one("post_rst", 54, 54);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic set_all_w(input logic [7:0] wv);
        for (int j = 0; j < 9; j++) w[j] = wv;
    endtask

    // Hard stop in case a wait above never returns.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/conv3x3_mac_seq.md
CONV3X3_MAC_SEQ -- requirements
Module: conv3x3_mac_seq

Interface
REQ-001 SHALL have parameter DW, default 8, data operand width (unsigned).
REQ-002 SHALL have parameter WW, default 8, weight operand width (signed two's complement).
REQ-003 SHALL have parameter ACC_W, default 21, accumulator width (signed).
REQ-004 SHALL have port clk, input, 1, clock: all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, level request to start one 3x3 dot product.
REQ-007 SHALL have ports data0..data8, input, DW each, window pixels in row-major order.
REQ-008 SHALL have ports weight0..weight8, input, WW each, kernel taps in row-major order.
REQ-009 SHALL have port ans, output, 8, ReLU-saturated result.
REQ-010 SHALL have port out_valid, output, 1, one-cycle pulse when ans is valid.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, MAC, DONE.
REQ-013 SHALL, when in IDLE and in_valid=1 at edge k, latch all 18 operands, clear the accumulator and tap counter, and enter MAC.
REQ-014 SHALL, in MAC, add one product data_i*weight_i per cycle, with i = tap counter 0..8; edges k+1..k+9 add taps 0..8.
REQ-015 SHALL compute each product as signed with data zero-extended, in a 17-bit field, and accumulate sign-extended to ACC_W without overflow (worst case fits 21 bits).
REQ-016 SHALL, at edge k+9, enter DONE, register ans and set out_valid=1.
REQ-017 SHALL, at edge k+10, clear out_valid and return to IDLE; ans SHALL hold its value until the next result.
REQ-018 SHALL set ans to 0 if acc<0, to 255 if acc>255, and to acc[7:0] otherwise.
REQ-019 SHALL ignore in_valid in MAC and DONE; deassertion mid-computation SHALL NOT abort it.
REQ-020 SHALL NOT sample new operands at the DONE->IDLE edge, so the initiator may update operands on out_valid.
REQ-021 SHALL, with in_valid held high, start the next computation at edge k+11, giving one result every 11 cycles.
REQ-022 SHALL use only the latched operands during MAC; input changes after edge k SHALL NOT affect the result.
REQ-023 SHALL keep busy=1 from edge k through edge k+10.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously set the state to IDLE and clear ans, out_valid, busy, the accumulator, the tap counter and the operand registers to 0.
REQ-025 SHALL abandon any computation in progress on mid-operation reset, with no out_valid produced for it.
REQ-026 SHALL treat the first edge with in_valid=1 after rst_n deasserts as edge k.

Structure
REQ-027 SHALL place DW, WW, ACC_W, the tap count (9) and the state encoding in shared package conv_pkg.
REQ-028 SHALL implement ReLU/saturation as a conv_pkg function; the block SHALL have no sub-module, and operand selection SHALL be a 9:1 mux indexed by the tap counter.

Verification
REQ-029 SHALL cover: all data=1, all weights=1, in_valid pulse at edge k -> out_valid only in the cycle after edge k+9, ans=9.
REQ-030 SHALL cover: data0..8=0..8, weights=1 -> ans=36; then all weights=-1 -> ans=0 (ReLU).
REQ-031 SHALL cover: all data=255, all weights=127 -> acc=291465, ans=255 (saturation); then data=255, weights=-128 -> acc=-293760, ans=0.
REQ-032 SHALL cover: in_valid held high for 40 cycles, with operands changed on each out_valid -> out_valid pulses 11 cycles apart, each ans matching its own operand set.
REQ-033 SHALL cover: operands changed to random values at edge k+3 -> ans reflects the operands latched at edge k.
REQ-034 SHALL cover: rst_n asserted at edge k+5 -> ans=0, out_valid=0, busy=0 immediately, no pulse follows, and the next request after release completes normally.
